// File: rtl/static_buff_sched.sv
// Round-robin pop scheduler and flow-control front end for a multi-FIFO static buffer.
// Shadow per-FIFO counts gate push/pop; a credit loop keeps returning read data from being lost.
module static_buff_sched #(
    parameter int unsigned NUMFIFO = 8,
    parameter int unsigned NUMELEM = 4,
    parameter int unsigned BITDATA = 4,
    parameter int unsigned RDLAT   = 1,
    parameter int unsigned BITFIFO = $clog2(NUMFIFO),
    parameter int unsigned BITELEM = $clog2(NUMELEM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buf_ready,
    input  logic               in_vld,
    input  logic [BITFIFO-1:0] in_prt,
    input  logic [BITDATA-1:0] in_din,
    output logic               in_rdy,
    output logic               buf_push,
    output logic [BITFIFO-1:0] buf_pu_prt,
    output logic [BITDATA-1:0] buf_pu_din,
    output logic               buf_pop,
    output logic [BITFIFO-1:0] buf_po_prt,
    input  logic [BITDATA-1:0] buf_po_dout,
    output logic               out_vld,
    output logic [BITFIFO-1:0] out_prt,
    output logic [BITDATA-1:0] out_dout,
    input  logic               out_rdy,
    output logic [NUMFIFO-1:0] nempty
);
    localparam int unsigned QDEPTH  = RDLAT + 1;
    localparam int unsigned BITQ    = $clog2(QDEPTH);
    localparam int unsigned BITCRED = $clog2(RDLAT + 2);
    localparam logic [BITELEM:0]   CntFull    = (BITELEM + 1)'(NUMELEM);
    localparam logic [BITCRED-1:0] CreditInit = BITCRED'(RDLAT + 1);
    localparam logic [BITQ-1:0]    QLast      = BITQ'(QDEPTH - 1);

    typedef enum logic {StInit, StRun} state_e;
    state_e state_q, state_d;

    logic [BITELEM:0]   cnt_q [NUMFIFO];
    logic [BITFIFO-1:0] rr_q;
    logic [BITCRED-1:0] credit_q;
    logic [RDLAT-1:0]   rd_vld_q;
    logic [BITFIFO-1:0] rd_prt_q [RDLAT];
    logic [BITFIFO-1:0] q_prt_q [QDEPTH];
    logic [BITDATA-1:0] q_dat_q [QDEPTH];
    logic [BITQ-1:0]    wr_q, rd_q;
    logic [BITCRED-1:0] qcnt_q;

    logic               go, any_elig, out_hs, q_wr;
    logic [BITFIFO-1:0] pick, idx;
    logic [NUMFIFO-1:0] push_vec, pop_vec;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  if (buf_ready) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        for (int unsigned f = 0; f < NUMFIFO; f++) begin
            nempty[f] = cnt_q[f] != '0;
        end
    end

    // First eligible FIFO at or after rr_q, wrapping modulo NUMFIFO.
    always_comb begin
        pick     = '0;
        idx      = '0;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < NUMFIFO; k++) begin
            idx = BITFIFO'((32'(rr_q) + k) % NUMFIFO);
            if (!any_elig && nempty[idx]) begin
                any_elig = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        go         = (state_q == StRun) && buf_ready;
        in_rdy     = go && (cnt_q[in_prt] < CntFull);
        buf_push   = in_vld && in_rdy;
        buf_pu_prt = in_prt;
        buf_pu_din = in_din;
        buf_pop    = go && (credit_q != '0) && any_elig;
        buf_po_prt = pick;
        out_vld    = qcnt_q != '0;
        out_prt    = q_prt_q[rd_q];
        out_dout   = q_dat_q[rd_q];
        out_hs     = out_vld && out_rdy;
        q_wr       = rd_vld_q[RDLAT-1];
        for (int unsigned f = 0; f < NUMFIFO; f++) begin
            push_vec[f] = buf_push && (in_prt == BITFIFO'(f));
            pop_vec[f]  = buf_pop && (pick == BITFIFO'(f));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StInit;
            rr_q     <= '0;
            credit_q <= CreditInit;
            rd_vld_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            qcnt_q   <= '0;
            for (int unsigned f = 0; f < NUMFIFO; f++) cnt_q[f] <= '0;
            for (int unsigned i = 0; i < RDLAT; i++) rd_prt_q[i] <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_prt_q[i] <= '0;
                q_dat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int unsigned f = 0; f < NUMFIFO; f++) begin
                case ({push_vec[f], pop_vec[f]})
                    2'b10:   cnt_q[f] <= cnt_q[f] + 1'b1;
                    2'b01:   cnt_q[f] <= cnt_q[f] - 1'b1;
                    default: ;
                endcase
            end
            if (buf_pop) rr_q <= BITFIFO'((32'(pick) + 1) % NUMFIFO);

            rd_vld_q[0] <= buf_pop;
            rd_prt_q[0] <= pick;
            for (int unsigned i = 1; i < RDLAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_prt_q[i] <= rd_prt_q[i-1];
            end

            // Tail of the read pipe lands in the output queue with the buffer's data.
            if (q_wr) begin
                q_prt_q[wr_q] <= rd_prt_q[RDLAT-1];
                q_dat_q[wr_q] <= buf_po_dout;
                wr_q          <= (wr_q == QLast) ? '0 : wr_q + 1'b1;
            end
            if (out_hs) rd_q <= (rd_q == QLast) ? '0 : rd_q + 1'b1;

            case ({q_wr, out_hs})
                2'b10:   qcnt_q <= qcnt_q + 1'b1;
                2'b01:   qcnt_q <= qcnt_q - 1'b1;
                default: ;
            endcase
            case ({buf_pop, out_hs})
                2'b10:   credit_q <= credit_q - 1'b1;
                2'b01:   credit_q <= credit_q + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_static_buff_sched.sv
// Bench for static_buff_sched: models the buffer and checks the scheduler every cycle against
// a queue-based reference; directed scenarios first, then randomized traffic.
module tb_static_buff_sched;
    localparam int unsigned NUMFIFO = 8;
    localparam int unsigned NUMELEM = 4;
    localparam int unsigned BITDATA = 4;
    localparam int unsigned RDLAT   = 1;
    localparam int unsigned BITFIFO = $clog2(NUMFIFO);
    localparam int unsigned BITENT  = BITFIFO + BITDATA;

    logic               clk;
    logic               rst, buf_ready, in_vld, in_rdy, buf_push, buf_pop, out_vld, out_rdy;
    logic [BITFIFO-1:0] in_prt, buf_pu_prt, buf_po_prt, out_prt;
    logic [BITDATA-1:0] in_din, buf_pu_din, buf_po_dout, out_dout;
    logic [NUMFIFO-1:0] nempty;

    static_buff_sched #(
        .NUMFIFO(NUMFIFO), .NUMELEM(NUMELEM), .BITDATA(BITDATA), .RDLAT(RDLAT)
    ) dut (
        .clk(clk), .rst(rst), .buf_ready(buf_ready),
        .in_vld(in_vld), .in_prt(in_prt), .in_din(in_din), .in_rdy(in_rdy),
        .buf_push(buf_push), .buf_pu_prt(buf_pu_prt), .buf_pu_din(buf_pu_din),
        .buf_pop(buf_pop), .buf_po_prt(buf_po_prt), .buf_po_dout(buf_po_dout),
        .out_vld(out_vld), .out_prt(out_prt), .out_dout(out_dout), .out_rdy(out_rdy),
        .nempty(nempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BITFIFO-1:0] prt;
        logic [BITDATA-1:0] dat;
        int                 rdy;
    } item_t;

    // Reference state: buffer contents per FIFO, reads in flight/queued, read-data delay line.
    logic [BITDATA-1:0] bufq [NUMFIFO][$];
    item_t              pend[$];
    logic [BITDATA-1:0] pipe [RDLAT];
    int unsigned        rr_m;
    int                 outstanding;
    bit                 run_m, model_ok;
    int                 cyc, n_tests, n_fail, dut_pops;
    logic [BITENT-1:0]  got[$], exp_log[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [BITENT-1:0] ent(input int unsigned p, input int unsigned d);
        return {BITFIFO'(p), BITDATA'(d)};
    endfunction

    task automatic check_log(input string tag);
        check({tag, "_len"}, got.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            check(tag, (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff, 32'(exp_log[i]));
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < NUMFIFO; f++) bufq[f].delete();
        for (int i = 0; i < RDLAT; i++) pipe[i] = '0;
        pend.delete();
        rr_m        = 0;
        outstanding = 0;
        run_m       = 1'b0;
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the reference.
    task automatic step(input bit r, input bit br, input bit iv, input int unsigned ip,
                        input int unsigned id, input bit ordy);
        bit                 exp_rdy, exp_push, exp_pop, exp_vld, found;
        logic [BITFIFO-1:0] exp_prt;
        logic [NUMFIFO-1:0] exp_ne;
        logic [BITDATA-1:0] newd;
        int unsigned        f;
        @(negedge clk);
        rst         = r;
        buf_ready   = br;
        in_vld      = iv;
        in_prt      = BITFIFO'(ip);
        in_din      = BITDATA'(id);
        out_rdy     = ordy;
        buf_po_dout = pipe[RDLAT-1];
        #1;
        for (int k = 0; k < NUMFIFO; k++) exp_ne[k] = bufq[k].size() != 0;
        exp_rdy  = run_m && br && (bufq[ip].size() < NUMELEM);
        exp_push = iv && exp_rdy;
        found    = 1'b0;
        exp_prt  = '0;
        for (int k = 0; k < NUMFIFO; k++) begin
            f = (rr_m + k) % NUMFIFO;
            if (!found && exp_ne[f]) begin
                found   = 1'b1;
                exp_prt = BITFIFO'(f);
            end
        end
        exp_pop = run_m && br && (outstanding < int'(RDLAT) + 1) && found;
        exp_vld = (pend.size() != 0) && (pend[0].rdy <= cyc);

        if (model_ok) begin
            check("in_rdy", in_rdy, exp_rdy);
            check("buf_push", buf_push, exp_push);
            if (exp_push) check("buf_pu", {buf_pu_prt, buf_pu_din}, {in_prt, in_din});
            check("buf_pop", buf_pop, exp_pop);
            if (exp_pop) check("buf_po_prt", buf_po_prt, exp_prt);
            check("out_vld", out_vld, exp_vld);
            if (exp_vld) check("out_entry", {out_prt, out_dout}, {pend[0].prt, pend[0].dat});
            check("nempty", nempty, exp_ne);
            if (out_vld && out_rdy) got.push_back({out_prt, out_dout});
            if (buf_pop) dut_pops++;
        end

        newd = '0;
        if (exp_pop) begin
            newd = bufq[exp_prt].pop_front();
            pend.push_back('{prt: exp_prt, dat: newd, rdy: cyc + int'(RDLAT) + 1});
            outstanding++;
            rr_m = (int'(exp_prt) + 1) % NUMFIFO;
        end
        if (exp_push) bufq[ip].push_back(BITDATA'(id));
        if (exp_vld && ordy) begin
            void'(pend.pop_front());
            outstanding--;
        end
        for (int i = RDLAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = newd;
        if (br) run_m = 1'b1;
        if (r) begin
            model_reset();
            model_ok = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1; buf_ready = 1'b0; in_vld = 1'b0; in_prt = '0; in_din = '0;
        out_rdy = 1'b0; buf_po_dout = '0;
        n_tests = 0; n_fail = 0; cyc = 0; dut_pops = 0; model_ok = 1'b0;
        model_reset();

        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rst_out_prt", out_prt, 0);
        check("rst_out_dout", out_dout, 0);
        check("rst_nempty", nempty, 0);

        // Buffer not ready: nothing accepted.
        repeat (5) step(0, 0, 1, 3, 9, 1);
        check("init_in_rdy", in_rdy, 0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 3, 0, 1);
        check("run_in_rdy", in_rdy, 1);

        // Fill FIFO 3 until full under backpressure, then drain in order.
        got.delete(); exp_log.delete();
        for (int v = 1; v <= 6; v++) step(0, 1, 1, 3, v, 0);
        step(0, 1, 1, 3, 7, 0);
        check("full_in_rdy", in_rdy, 0);
        check("full_push", buf_push, 0);
        repeat (12) step(0, 1, 0, 0, 0, 1);
        for (int v = 1; v <= 6; v++) exp_log.push_back(ent(3, v));
        check_log("fifo3_order");
        check("fifo3_nempty", nempty[3], 0);

        // Credits exhausted on FIFO 0, leaving rr at 1; then 6,1,2 queue up.
        got.delete(); exp_log.delete();
        step(0, 1, 1, 0, 7, 0);
        step(0, 1, 1, 0, 8, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 6, 9, 0);
        step(0, 1, 1, 1, 10, 0);
        step(0, 1, 1, 2, 11, 0);
        repeat (12) step(0, 1, 0, 0, 0, 1);
        exp_log = '{ent(0, 7), ent(0, 8), ent(1, 10), ent(2, 11), ent(6, 9)};
        check_log("rr_order");

        // Backpressure: only RDLAT+1 pops may be outstanding.
        got.delete(); exp_log.delete(); dut_pops = 0;
        for (int v = 1; v <= 4; v++) step(0, 1, 1, 0, v, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0);
        check("bp_pops", dut_pops, RDLAT + 1);
        repeat (12) step(0, 1, 0, 0, 0, 1);
        for (int v = 1; v <= 4; v++) exp_log.push_back(ent(0, v));
        check_log("bp_drain");

        // Concurrent push and pop on FIFO 5.
        got.delete(); exp_log.delete();
        for (int v = 1; v <= 4; v++) step(0, 1, 1, 5, v, 0);
        for (int v = 5; v <= 8; v++) step(0, 1, 1, 5, v, 1);
        repeat (14) step(0, 1, 0, 0, 0, 1);
        for (int v = 1; v <= 8; v++) exp_log.push_back(ent(5, v));
        check_log("fifo5_order");

        // Reset with reads in flight: nothing stale may emerge.
        got.delete();
        step(0, 1, 1, 4, 3, 0);
        step(0, 1, 1, 4, 5, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        check("rst_flight_vld", out_vld, 0);
        check("rst_flight_nempty", nempty, 0);
        repeat (8) step(0, 1, 0, 0, 0, 1);
        check("rst_no_stale", got.size(), 0);

        repeat (3000) begin
            step($urandom_range(299) == 0, $urandom_range(15) != 0, $urandom_range(9) < 6,
                 ($urandom_range(1) != 0) ? $urandom_range(2) : $urandom_range(NUMFIFO - 1),
                 $urandom_range((1 << BITDATA) - 1), $urandom_range(9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
